// File: rtl/ll_pkg.sv
// Shared definitions for the LocalLink transmit frame generator.
// Contents: FSM state encoding, Ethernet header field sizes and payload
// limits, a byte selector for 48-bit MAC addresses, and the payload
// length clamp applied when a frame request is captured.
package ll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DA      = 3'd1,
    ST_SA      = 3'd2,
    ST_TYPE    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  localparam int MAC_ADDR_BYTES = 6;
  localparam int TYPE_BYTES     = 2;
  localparam int MIN_PAYLOAD    = 46;
  localparam int MAX_PAYLOAD    = 1500;

  // Byte n of a MAC address, n = 0 being the most significant (first on the wire).
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] n);
    logic [47:0] sh;
    sh = addr << {n, 3'b000};
    return sh[47:40];
  endfunction

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    if (l < 11'(MIN_PAYLOAD)) return 11'(MIN_PAYLOAD);
    else if (l > 11'(MAX_PAYLOAD)) return 11'(MAX_PAYLOAD);
    else return l;
  endfunction

endpackage

// File: rtl/ll_tx_frame_gen.sv
// LocalLink transmit frame source. On start it emits one Ethernet frame
// (DA, SA, type/length, incrementing payload) byte by byte, honouring
// destination back-pressure, then holds busy for a programmable idle gap.
//
// Ports:
//   tx_ll_clock          clock
//   tx_ll_reset_n        asynchronous active-low reset
//   start                frame request, only looked at in IDLE
//   payload_len[10:0]    requested payload bytes, clamped to 46..1500
//   busy                 frame or gap in progress
//   frame_count[15:0]    frames completed, wrapping
//   tx_ll_data_out[7:0]  frame byte
//   tx_ll_sof_out_n      start of frame, active-low
//   tx_ll_eof_out_n      end of frame, active-low
//   tx_ll_src_rdy_out_n  beat valid, active-low
//   tx_ll_dst_rdy_in_n   sink ready, active-low
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start, all LocalLink strobes deasserted
// DA       | presenting destination address byte cnt (0..5)
// SA       | presenting source address byte cnt (0..5)
// TYPE     | presenting type/length byte cnt (0..1), MSB first
// PAYLOAD  | presenting payload byte cnt (0..len-1), eof on the last
// GAP      | inter-frame idle, cnt counts down to zero
//
// The output registers always hold the beat currently offered; cnt_q is
// that beat's index within its state. Everything advances only when the
// offered beat is accepted, so a stall freezes all outputs.
module ll_tx_frame_gen
  import ll_pkg::*;
#(
  parameter logic [47:0] DEST_ADDR  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_ADDR   = 48'h0A35_0001_0203,
  parameter logic [15:0] ETH_TYPE   = 16'h0000,
  parameter logic [7:0]  PAT_SEED   = 8'h00,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        tx_ll_clock,
  input  logic        tx_ll_reset_n,
  input  logic        start,
  input  logic [10:0] payload_len,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  tx_ll_data_out,
  output logic        tx_ll_sof_out_n,
  output logic        tx_ll_eof_out_n,
  output logic        tx_ll_src_rdy_out_n,
  input  logic        tx_ll_dst_rdy_in_n
);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        busy_q, busy_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        xfer;
  logic [10:0] cnt_inc;
  logic [15:0] type_val;

  always_ff @(posedge tx_ll_clock or negedge tx_ll_reset_n) begin
    if (!tx_ll_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      data_q        <= '0;
      sof_n_q       <= 1'b1;
      eof_n_q       <= 1'b1;
      src_rdy_n_q   <= 1'b1;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      data_q        <= data_d;
      sof_n_q       <= sof_n_d;
      eof_n_q       <= eof_n_d;
      src_rdy_n_q   <= src_rdy_n_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    data_d        = data_q;
    sof_n_d       = sof_n_q;
    eof_n_d       = eof_n_q;
    src_rdy_n_d   = src_rdy_n_q;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;

    xfer     = ~src_rdy_n_q & ~tx_ll_dst_rdy_in_n;
    cnt_inc  = cnt_q + 11'd1;
    // A zero type parameter means the field carries the captured length.
    type_val = (ETH_TYPE != 16'h0000) ? ETH_TYPE : {5'b0, len_q};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = clamp_len(payload_len);
          state_d     = ST_DA;
          cnt_d       = '0;
          data_d      = addr_byte(DEST_ADDR, 3'd0);
          sof_n_d     = 1'b0;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b0;
          busy_d      = 1'b1;
        end
      end

      ST_DA: begin
        if (xfer) begin
          sof_n_d = 1'b1;
          if (cnt_q == 11'(MAC_ADDR_BYTES - 1)) begin
            state_d = ST_SA;
            cnt_d   = '0;
            data_d  = addr_byte(SRC_ADDR, 3'd0);
          end else begin
            cnt_d  = cnt_inc;
            data_d = addr_byte(DEST_ADDR, cnt_inc[2:0]);
          end
        end
      end

      ST_SA: begin
        if (xfer) begin
          if (cnt_q == 11'(MAC_ADDR_BYTES - 1)) begin
            state_d = ST_TYPE;
            cnt_d   = '0;
            data_d  = type_val[15:8];
          end else begin
            cnt_d  = cnt_inc;
            data_d = addr_byte(SRC_ADDR, cnt_inc[2:0]);
          end
        end
      end

      ST_TYPE: begin
        if (xfer) begin
          if (cnt_q == 11'(TYPE_BYTES - 1)) begin
            state_d = ST_PAYLOAD;
            cnt_d   = '0;
            data_d  = PAT_SEED;
            eof_n_d = ~(len_q == 11'd1);
          end else begin
            cnt_d  = cnt_inc;
            data_d = type_val[7:0];
          end
        end
      end

      ST_PAYLOAD: begin
        if (xfer) begin
          if (!eof_n_q) begin
            src_rdy_n_d   = 1'b1;
            eof_n_d       = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (IFG_CYCLES == 0) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
              // Terminal count at zero, so load one less than the gap length.
              cnt_d   = 11'(IFG_CYCLES) - 11'd1;
            end
          end else begin
            cnt_d   = cnt_inc;
            data_d  = PAT_SEED + cnt_inc[7:0];
            eof_n_d = ~(cnt_inc == (len_q - 11'd1));
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == 11'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        src_rdy_n_d = 1'b1;
        sof_n_d     = 1'b1;
        eof_n_d     = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign busy                = busy_q;
  assign frame_count         = frame_count_q;
  assign tx_ll_data_out      = data_q;
  assign tx_ll_sof_out_n     = sof_n_q;
  assign tx_ll_eof_out_n     = eof_n_q;
  assign tx_ll_src_rdy_out_n = src_rdy_n_q;

endmodule

// File: tb/tb_ll_tx_frame_gen.sv
module tb_ll_tx_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] payload_len;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  data;
  logic        sof_n, eof_n, src_rdy_n;
  logic        dst_rdy_n;

  always #5 clk = ~clk;

  ll_tx_frame_gen dut (
    .tx_ll_clock         (clk),
    .tx_ll_reset_n       (rst_n),
    .start               (start),
    .payload_len         (payload_len),
    .busy                (busy),
    .frame_count         (frame_count),
    .tx_ll_data_out      (data),
    .tx_ll_sof_out_n     (sof_n),
    .tx_ll_eof_out_n     (eof_n),
    .tx_ll_src_rdy_out_n (src_rdy_n),
    .tx_ll_dst_rdy_in_n  (dst_rdy_n)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] cap_data [0:1599];
  logic       cap_sof  [0:1599];
  logic       cap_eof  [0:1599];

  typedef struct {
    logic [10:0] plen;
    bit          stall;
    int          beats;
    logic [7:0]  th;
    logic [7:0]  tl;
    logic [7:0]  last;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int len);
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] ty;
    da = 48'hFFFF_FFFF_FFFF;
    sa = 48'h0A35_0001_0203;
    ty = 16'(len);
    if (i < 6)        return da[47-8*i -: 8];
    else if (i < 12)  return sa[47-8*(i-6) -: 8];
    else if (i == 12) return ty[15:8];
    else if (i == 13) return ty[7:0];
    else              return 8'(i - 14);
  endfunction

  // Starts a frame at a negedge and collects it. On return the bench sits
  // at the negedge where busy has dropped (or the gap bound expired).
  task automatic send_frame(input logic [10:0] plen, input bit stall, input bit pulses,
                            output int nbeats, output int proto_err, output int gap_cyc);
    int  cyc;
    bit  dst;
    bit  prev_stall;
    bit  done;
    logic [10:0] prev_out;
    nbeats = 0; proto_err = 0; gap_cyc = 0; prev_stall = 0; done = 0;
    prev_out = '0;
    @(negedge clk);
    start = 1'b1; payload_len = plen; dst_rdy_n = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("first_beat_src_sof_busy", {29'd0, src_rdy_n, sof_n, busy}, 32'b001);
    cyc = 0;
    while (!done && cyc < 6000) begin
      if (prev_stall && ({data, sof_n, eof_n, src_rdy_n} !== prev_out)) proto_err++;
      if (src_rdy_n !== 1'b0) proto_err++;
      dst = stall ? (cyc % 2 == 0) : 1'b0;
      dst_rdy_n = dst;
      start = pulses && !dst && (nbeats == 5 || nbeats == 40);
      prev_out = {data, sof_n, eof_n, src_rdy_n};
      prev_stall = dst;
      if (!dst && nbeats < 1600) begin
        cap_data[nbeats] = data;
        cap_sof[nbeats]  = sof_n;
        cap_eof[nbeats]  = eof_n;
        nbeats++;
        if (eof_n === 1'b0) done = 1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    dst_rdy_n = 1'b0;
    check("frame_completed", {31'd0, done}, 32'd1);
    check("post_eof_src_eof_busy", {29'd0, src_rdy_n, eof_n, busy}, 32'b111);
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      gap_cyc++;
      start = pulses && (gap_cyc == 3);
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
  endtask

  task automatic verify_frame(input string tag, input int nbeats, input int len);
    int byte_err, mark_err;
    byte_err = 0; mark_err = 0;
    for (int i = 0; i < nbeats && i < 1600; i++) begin
      if (cap_data[i] !== exp_byte(i, len)) byte_err++;
      if (cap_sof[i] !== (i != 0)) mark_err++;
      if (cap_eof[i] !== (i != nbeats - 1)) mark_err++;
    end
    check({tag, "_byte_errs"}, byte_err, 0);
    check({tag, "_sof_eof_errs"}, mark_err, 0);
  endtask

  initial begin
    int nb, pe, gc;
    logic [15:0] exp_fc;
    int eof_seen;

    vecs[0] = '{11'd46,   1'b0, 60,   8'h00, 8'h2E, 8'h2D};
    vecs[1] = '{11'd10,   1'b0, 60,   8'h00, 8'h2E, 8'h2D};
    vecs[2] = '{11'd2000, 1'b0, 1514, 8'h05, 8'hDC, 8'hDB};
    vecs[3] = '{11'd46,   1'b1, 60,   8'h00, 8'h2E, 8'h2D};
    vecs[4] = '{11'd100,  1'b1, 114,  8'h00, 8'h64, 8'h63};
    vecs[5] = '{11'd45,   1'b0, 60,   8'h00, 8'h2E, 8'h2D};
    vecs[6] = '{11'd47,   1'b0, 61,   8'h00, 8'h2F, 8'h2E};
    vecs[7] = '{11'd1501, 1'b1, 1514, 8'h05, 8'hDC, 8'hDB};

    rst_n = 1'b0; start = 1'b0; payload_len = '0; dst_rdy_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {data, sof_n, eof_n, src_rdy_n, busy}, {8'h00, 4'b1110});
    check("reset_frame_count", {16'd0, frame_count}, 32'd0);
    rst_n = 1'b1;
    exp_fc = 16'd0;

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].plen, vecs[v].stall, 1'b0, nb, pe, gc);
      exp_fc = exp_fc + 16'd1;
      check($sformatf("v%0d_beats", v), nb, vecs[v].beats);
      check($sformatf("v%0d_type_hi", v), {24'd0, cap_data[12]}, {24'd0, vecs[v].th});
      check($sformatf("v%0d_type_lo", v), {24'd0, cap_data[13]}, {24'd0, vecs[v].tl});
      if (nb > 0)
        check($sformatf("v%0d_last_byte", v), {24'd0, cap_data[nb-1]}, {24'd0, vecs[v].last});
      check($sformatf("v%0d_protocol", v), pe, 0);
      check($sformatf("v%0d_gap_cycles", v), gc, 12);
      check($sformatf("v%0d_frame_count", v), {16'd0, frame_count}, {16'd0, exp_fc});
      verify_frame($sformatf("v%0d", v), nb, vecs[v].beats - 14);
    end

    // Starts during DA, payload and gap must all be dropped.
    send_frame(11'd46, 1'b0, 1'b1, nb, pe, gc);
    exp_fc = exp_fc + 16'd1;
    check("ign_beats", nb, 60);
    check("ign_gap_cycles", gc, 12);
    verify_frame("ign", nb, 46);
    repeat (4) @(negedge clk);
    check("ign_stays_idle", {30'd0, busy, src_rdy_n}, 32'b01);
    check("ign_frame_count", {16'd0, frame_count}, {16'd0, exp_fc});

    // Reset while payload beat 20 is on the bus.
    @(negedge clk);
    start = 1'b1; payload_len = 11'd46; dst_rdy_n = 1'b0;
    @(negedge clk);
    start = 1'b0;
    eof_seen = 0;
    for (int k = 0; k < 34; k++) begin
      if (eof_n === 1'b0) eof_seen++;
      @(negedge clk);
    end
    check("rst_mid_data_before", {24'd0, data}, 32'h14);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {data, sof_n, eof_n, src_rdy_n, busy}, {8'h00, 4'b1110});
    check("rst_mid_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_mid_no_eof", eof_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = 16'd0;
    send_frame(11'd46, 1'b0, 1'b0, nb, pe, gc);
    exp_fc = exp_fc + 16'd1;
    check("after_rst_beats", nb, 60);
    check("after_rst_protocol", pe, 0);
    verify_frame("after_rst", nb, 46);
    check("after_rst_frame_count", {16'd0, frame_count}, {16'd0, exp_fc});

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    send_frame(11'd50, 1'b0, 1'b0, nb, pe, gc);
    check("wrap_beats", nb, 64);
    verify_frame("wrap", nb, 50);
    check("wrap_frame_count", {16'd0, frame_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
